fifo_rd_stream: RTL



---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_skid2.sv | 53 +++++
 rtl/fifo_rd_stream.sv | 61 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the fifo_array read-side stream master.
package fifo_pkg;

    localparam int DEF_SIZE_DATA = 8;
    localparam int SKID_DEPTH    = 2;
    localparam int OCC_W         = $clog2(SKID_DEPTH + 1);

    typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry register skid buffer with 1-bit head/tail pointers.
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int SIZE_DATA = DEF_SIZE_DATA
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic [SIZE_DATA-1:0] i_push_data,
    input  logic                 i_pop,
    output logic [SIZE_DATA-1:0] o_head,
    output occ_t                 o_occ
);

    logic [SIZE_DATA-1:0] mem_q [SKID_DEPTH];
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    occ_t                 occ_q,  occ_d;
    logic                 pop_ok;

    // NOTE: every signal gets a default on entry, so no path leaves a value held and no latch is inferred.
    always_comb begin
        pop_ok = i_pop && (occ_q != '0);
        head_d = head_q ^ pop_ok;
        tail_d = tail_q ^ i_push;
        occ_d  = occ_q + occ_t'(i_push) - occ_t'(pop_ok);
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the entries are reset too, so the head reads as zero coming out of reset.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= '0;
        end else begin
            if (i_push) begin
                mem_q[tail_q] <= i_push_data;
            end
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign o_head = mem_q[head_q];
    assign o_occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains fifo_array through its read port and re-times the words onto a valid/ready stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int SIZE_DATA = DEF_SIZE_DATA,
    parameter int SIZE_CNT  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_fifo_empty,
    input  logic [SIZE_DATA-1:0] i_fifo_data,
    output logic                 o_fifo_rd_en,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_data,
    output logic [SIZE_CNT-1:0]  o_cnt
);

    logic                infl_q, infl_d;
    logic [SIZE_CNT-1:0] cnt_q,  cnt_d;
    occ_t                skid_occ;
    logic                pop;
    logic [OCC_W:0]      committed;

    assign o_valid = (skid_occ != '0);

    // A read is only issued if the word it returns is guaranteed a free skid slot.
    always_comb begin
        pop          = o_valid && i_ready;
        committed    = (OCC_W+1)'(skid_occ) + (OCC_W+1)'(infl_q);
        o_fifo_rd_en = !i_rst && !i_fifo_empty
                       && (committed < (OCC_W+1)'(SKID_DEPTH) + (OCC_W+1)'(pop));
        infl_d       = o_fifo_rd_en;
        cnt_d        = cnt_q + SIZE_CNT'(pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            infl_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            infl_q <= infl_d;
            cnt_q  <= cnt_d;
        end
    end

    fifo_skid2 #(
        .SIZE_DATA (SIZE_DATA)
    ) u_skid (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (infl_q),
        .i_push_data (i_fifo_data),
        .i_pop       (pop),
        .o_head      (o_data),
        .o_occ       (skid_occ)
    );

    assign o_cnt = cnt_q;

endmodule
